// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - iterative MULT/MADD/MSUB/DIV unit for EX; divider compiled in with MULDIV_DIV_EN
module ex_muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, DONE} state_t;
    state_t state, state_next;

    // op_i[2:1] is all the sequencing needs: 00 mult, 01 madd, 10 msub, 11 div
    logic [1:0]       op_cls;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_b;
    // multiplicand shifted up each step; low half doubles as dividend/quotient
    logic [DW-1:0]    mcand;
    // product accumulator; low half doubles as the partial remainder
    logic [DW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic             neg_a_in, neg_b_in, is_div_in, accept;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [DW-1:0]    pp, prod_sum, prod_fin;
    logic             load;
    logic [DW-1:0]    res;

    // Issue-side decode: operand magnitudes, sign flags, acceptance
    always_comb begin
        neg_a_in  = ~op_i[0] & opa_i[WIDTH-1];
        neg_b_in  = ~op_i[0] & opb_i[WIDTH-1];
        mag_a_in  = neg_a_in ? -opa_i : opa_i;
        mag_b_in  = neg_b_in ? -opb_i : opb_i;
        is_div_in = op_i[2] & op_i[1];
`ifdef MULDIV_DIV_EN
        accept    = start_i & ~flush_i;
`else
        accept    = start_i & ~flush_i & ~is_div_in;
`endif
    end

    // One shift-add step: retire MUL_STEP multiplier bits, sign-fix the final sum
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mag_b[i]) pp = pp + (mcand << i);
        end
        prod_sum = acc + pp;
        prod_fin = (sign_a ^ sign_b) ? -prod_sum : prod_sum;
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next, quo_next, quo_fin, rem_fin;

    // One restoring-division step; remainder stays below the divisor so bit WIDTH is the borrow
    always_comb begin
        rem_sh   = {acc[WIDTH-1:0], mcand[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mag_b};
        rem_ge   = ~rem_diff[WIDTH];
        rem_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {mcand[WIDTH-2:0], rem_ge};
        quo_fin  = (sign_a ^ sign_b) ? -quo_next : quo_next;
        rem_fin  = sign_a ? -rem_next : rem_next;
    end
`endif

    // Next state, stall request and result select
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        load       = 1'b0;
        res        = prod_fin;
        case (state)
            IDLE: begin
                busy_o = accept;
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    if (is_div_in) begin
                        if (opb_i == '0) begin
                            state_next = DONE;
                            load       = 1'b1;
                            res        = {opa_i, {WIDTH{1'b1}}};
                        end else begin
                            state_next = DIV;
                        end
                    end else begin
                        state_next = MUL;
                    end
`else
                    state_next = MUL;
`endif
                end
            end
            MUL: begin
                busy_o = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    if (op_cls == 2'b00) begin
                        state_next = DONE;
                        load       = 1'b1;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            ACC: begin
                busy_o     = 1'b1;
                state_next = DONE;
                load       = 1'b1;
                res        = op_cls[1] ? ({hi_i, lo_i} - acc) : ({hi_i, lo_i} + acc);
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                busy_o = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                    load       = 1'b1;
                    res        = {rem_fin, quo_fin};
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
            load       = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cls <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_b  <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_cls <= op_i[2:1];
                        sign_a <= neg_a_in;
                        sign_b <= neg_b_in;
                        mag_b  <= mag_b_in;
                        mcand  <= {{WIDTH{1'b0}}, mag_a_in};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    mcand <= mcand << MUL_STEP;
                    mag_b <= mag_b >> MUL_STEP;
                    acc   <= (cnt == CW'(N - 1)) ? prod_fin : prod_sum;
                    cnt   <= cnt + CW'(1);
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    mcand[WIDTH-1:0] <= quo_next;
                    acc[WIDTH-1:0]   <= rem_next;
                    cnt              <= cnt + CW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Registered HI/LO write port; results hold between completions
    always_ff @(posedge clk) begin
        if (rst) begin
            whilo_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            whilo_o <= load;
            if (load) {hi_o, lo_o} <= res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// tb/tb_ex_muldiv_iter.sv - self-checking bench for ex_muldiv_iter with a result scoreboard
module tb_ex_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i, busy_o, whilo_o;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i, hi_i, lo_i, hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    ex_muldiv_iter #(.WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
        .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i), .busy_o(busy_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, h, l);
        logic [63:0] xa, xb, p, hl, out;
        longint da, db, q, r;
        xa = op[0] ? {32'h0, a} : {{32{a[31]}}, a};
        xb = op[0] ? {32'h0, b} : {{32{b[31]}}, b};
        p  = xa * xb;
        hl = {h, l};
        da = longint'(xa);
        db = longint'(xb);
        out = '0;
        case (op)
            3'd0, 3'd1: out = p;
            3'd2, 3'd3: out = hl + p;
            3'd4, 3'd5: out = hl - p;
            default: begin
                if (b == 32'h0) out = {a, 32'hFFFFFFFF};
                else begin
                    q = da / db;
                    r = da % db;
                    out = {r[31:0], q[31:0]};
                end
            end
        endcase
        return out;
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd1) return 17;
        if (op <= 3'd5) return 18;
        if (b == 32'h0) return 1;
        return 33;
    endfunction

    // Drive one op from the current cycle (cycle 0) and observe until completion
    task automatic run(input logic [2:0] op, input logic [31:0] a, b, h, l,
                       input int hchg_cyc, input logic [31:0] hchg_val,
                       output int lat, output int busy_cnt, output int whilo_cnt,
                       output logic [31:0] got_hi, output logic [31:0] got_lo);
        lat = -1; busy_cnt = 0; whilo_cnt = 0; got_hi = '0; got_lo = '0;
        op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l; start_i = 1'b1;
        #1;
        if (busy_o) busy_cnt++;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            opa_i = $urandom;
            opb_i = $urandom;
            op_i  = 3'($urandom_range(0, 7));
            if (k == hchg_cyc) hi_i = hchg_val;
            #1;
            if (whilo_o) begin
                lat = k; got_hi = hi_o; got_lo = lo_o; whilo_cnt++; start_i = 1'b0;
            end else if (busy_o) busy_cnt++;
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        if (whilo_o) whilo_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_checks++; if (whilo_o !== 1'b0) begin n_fail++; $display("FAIL reset_whilo got %b exp 0", whilo_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", lo_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_mul();
        logic [2:0] op; logic [31:0] a, b, gh, gl; logic [63:0] e; int el, lat, bc, wc;
        for (int t = 0; t < 6; t++) begin
            if (t == 0)      begin op = 3'd0; a = 32'hFFFFFFFF; b = 32'd2; e = 64'hFFFFFFFF_FFFFFFFE; end
            else if (t == 1) begin op = 3'd1; a = 32'hFFFFFFFF; b = 32'd2; e = 64'h00000001_FFFFFFFE; end
            else begin op = 3'(t % 2); a = $urandom; b = $urandom; e = model(op, a, b, 32'h0, 32'h0); end
            exp_q.push_back(e); lat_q.push_back(17);
            run(op, a, b, 32'h0, 32'h0, 0, 32'h0, lat, bc, wc, gh, gl);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_checks++; if ({gh, gl} !== e) begin n_fail++; $display("FAIL mul_result t=%0d op=%0d got %h exp %h", t, op, {gh, gl}, e); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL mul_latency t=%0d got %0d exp %0d", t, lat, el); end
            n_checks++; if (bc !== el) begin n_fail++; $display("FAIL mul_busy_cycles t=%0d got %0d exp %0d", t, bc, el); end
            n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL mul_whilo_cycles t=%0d got %0d exp 1", t, wc); end
        end
    endtask

    task automatic test_acc();
        logic [2:0] op; logic [31:0] a, b, h, l, gh, gl, hv; logic [63:0] e; int el, lat, bc, wc, hc;
        for (int t = 0; t < 6; t++) begin
            hc = 0; hv = 32'h0;
            if (t == 0) begin
                op = 3'd2; a = 32'd3; b = 32'd4; h = 32'hDEAD0000; l = 32'd5; hc = 17; hv = 32'h0;
                e = 64'h00000000_00000011;
            end else if (t == 1) begin
                op = 3'd5; a = 32'd3; b = 32'd7; h = 32'h0; l = 32'h10; e = 64'hFFFFFFFF_FFFFFFFB;
            end else begin
                op = 3'($urandom_range(2, 5)); a = $urandom; b = $urandom; h = $urandom; l = $urandom;
                e = model(op, a, b, h, l);
            end
            exp_q.push_back(e); lat_q.push_back(18);
            run(op, a, b, h, l, hc, hv, lat, bc, wc, gh, gl);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_checks++; if ({gh, gl} !== e) begin n_fail++; $display("FAIL acc_result t=%0d op=%0d got %h exp %h", t, op, {gh, gl}, e); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL acc_latency t=%0d got %0d exp %0d", t, lat, el); end
            n_checks++; if (bc !== el) begin n_fail++; $display("FAIL acc_busy_cycles t=%0d got %0d exp %0d", t, bc, el); end
            n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL acc_whilo_cycles t=%0d got %0d exp 1", t, wc); end
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [2:0] op; logic [31:0] a, b, gh, gl; logic [63:0] e; int el, lat, bc, wc;
        for (int t = 0; t < 7; t++) begin
            if (t == 0)      begin op = 3'd6; a = -32'sd7; b = 32'd2; e = 64'hFFFFFFFF_FFFFFFFD; el = 33; end
            else if (t == 1) begin op = 3'd7; a = 32'h1234; b = 32'd0; e = 64'h00001234_FFFFFFFF; el = 1; end
            else if (t == 2) begin op = 3'd6; a = 32'h80000005; b = 32'd0; e = 64'h80000005_FFFFFFFF; el = 1; end
            else begin
                op = 3'(6 + (t % 2)); a = $urandom; b = (t == 3) ? 32'hFFFFFFF9 : $urandom_range(1, 1000);
                e = model(op, a, b, 32'h0, 32'h0); el = lat_of(op, b);
            end
            exp_q.push_back(e); lat_q.push_back(el);
            run(op, a, b, 32'h0, 32'h0, 0, 32'h0, lat, bc, wc, gh, gl);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_checks++; if ({gh, gl} !== e) begin n_fail++; $display("FAIL div_result t=%0d op=%0d got %h exp %h", t, op, {gh, gl}, e); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL div_latency t=%0d got %0d exp %0d", t, lat, el); end
            n_checks++; if (bc !== el) begin n_fail++; $display("FAIL div_busy_cycles t=%0d got %0d exp %0d", t, bc, el); end
            n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL div_whilo_cycles t=%0d got %0d exp 1", t, wc); end
        end
    endtask
`else
    task automatic test_div_disabled();
        int bc, wc;
        for (int t = 6; t <= 7; t++) begin
            bc = 0; wc = 0;
            op_i = 3'(t); opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
            #1;
            if (busy_o) bc++;
            repeat (3) begin @(negedge clk); #1; if (busy_o) bc++; if (whilo_o) wc++; end
            start_i = 1'b0;
            repeat (40) begin @(negedge clk); #1; if (busy_o) bc++; if (whilo_o) wc++; end
            n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL div_off_busy op=%0d got %0d busy cycles exp 0", t, bc); end
            n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL div_off_whilo op=%0d got %0d whilo cycles exp 0", t, wc); end
        end
    endtask
`endif

    task automatic test_flush();
        logic [31:0] a, b, gh, gl; logic [63:0] e; int el, lat, bc, wc, fw;
        fw = 0;
        op_i = 3'd0; opa_i = 32'h12345678; opb_i = 32'h9; start_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) flush_i = 1'b1;
            if (k == 6) begin flush_i = 1'b0; start_i = 1'b0; end
            #1;
            if (whilo_o) fw++;
        end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b exp 0", busy_o); end
        a = $urandom; b = $urandom;
        exp_q.push_back(model(3'd1, a, b, 32'h0, 32'h0)); lat_q.push_back(17);
        run(3'd1, a, b, 32'h0, 32'h0, 0, 32'h0, lat, bc, wc, gh, gl);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++; if (fw !== 0) begin n_fail++; $display("FAIL flush_whilo got %0d cycles exp 0", fw); end
        n_checks++; if ({gh, gl} !== e) begin n_fail++; $display("FAIL flush_next_result got %h exp %h", {gh, gl}, e); end
        n_checks++; if (lat !== el) begin n_fail++; $display("FAIL flush_next_latency got %0d exp %0d", lat, el); end
        n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL flush_next_whilo got %0d exp 1", wc); end
        op_i = 3'd0; start_i = 1'b1; flush_i = 1'b1;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got %b exp 0", busy_o); end
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_blocked got busy %b exp 0", busy_o); end
    endtask

    task automatic test_rst_mid();
        int wc;
        wc = 0;
`ifdef MULDIV_DIV_EN
        op_i = 3'd6;
`else
        op_i = 3'd2;
`endif
        opa_i = -32'sd100; opb_i = 32'd7; hi_i = 32'd1; lo_i = 32'd2; start_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) rst = 1'b1;
            #1;
            if (whilo_o) wc++;
        end
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
        n_checks++; if (whilo_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_whilo got %b exp 0", whilo_o); end
        n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h exp 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h exp 0", lo_o); end
        repeat (40) begin @(negedge clk); #1; if (whilo_o) wc++; end
        n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL rst_mid_no_write got %0d whilo cycles exp 0", wc); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[8]; logic [31:0] as[8], bs[8], hs[8], ls[8];
        logic [31:0] gh, gl; logic [63:0] e; int el, lat, bc, wc;
        for (int t = 0; t < 8; t++) begin
`ifdef MULDIV_DIV_EN
            ops[t] = 3'($urandom_range(0, 7));
`else
            ops[t] = 3'($urandom_range(0, 5));
`endif
            as[t] = $urandom; bs[t] = (t == 3) ? 32'h0 : $urandom; hs[t] = $urandom; ls[t] = $urandom;
            exp_q.push_back(model(ops[t], as[t], bs[t], hs[t], ls[t]));
            lat_q.push_back(lat_of(ops[t], bs[t]));
        end
        for (int t = 0; t < 8; t++) begin
            run(ops[t], as[t], bs[t], hs[t], ls[t], 0, 32'h0, lat, bc, wc, gh, gl);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_checks++; if ({gh, gl} !== e) begin n_fail++; $display("FAIL b2b_result t=%0d op=%0d got %h exp %h", t, ops[t], {gh, gl}, e); end
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL b2b_latency t=%0d got %0d exp %0d", t, lat, el); end
            n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL b2b_whilo t=%0d got %0d exp 1", t, wc); end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
        test_reset();
        test_mul();
        test_acc();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
